// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: restoring divide, shift-add or single-cycle multiply.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; the default is iterative shift-add.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [2:0]       op;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opB;
  logic             negRes;

  logic             accept;
  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic             divZero;
  logic             divOvf;
  logic             special;
  logic             negAccept;
  logic [WIDTH-1:0] specialResult;

  assign accept  = start & (state != CALC);
  assign signA   = data1[WIDTH-1] &
                   ((select == OP_MULH) | (select == OP_MULHSU) | (select == OP_DIV) | (select == OP_REM));
  assign signB   = data2[WIDTH-1] & ((select == OP_MULH) | (select == OP_DIV) | (select == OP_REM));
  assign absA    = signA ? -data1 : data1;
  assign absB    = signB ? -data2 : data2;
  assign divZero = select[2] & (data2 == '0);
  assign divOvf  = ((select == OP_DIV) | (select == OP_REM)) &
                   (data1 == {1'b1, {(WIDTH-1){1'b0}}}) & (data2 == '1);
  assign special = divZero | divOvf;
  // Remainder takes the dividend's sign; quotient and product take the XOR of both signs.
  assign negAccept = (select[2] & select[1]) ? signA : (signA ^ signB);

  always_comb begin
    specialResult = '0;
    if (divZero)
      specialResult = select[1] ? data1 : '1;
    else
      specialResult = select[1] ? '0 : data1;
  end

  // One iteration step: hi/lo hold partial product or remainder/quotient.
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic               divOk;
  logic [WIDTH-1:0]   divDiff;
  logic [WIDTH-1:0]   nextHi;
  logic [WIDTH-1:0]   nextLo;
  logic [2*WIDTH-1:0] mulFull;
  logic [WIDTH-1:0]   divOut;
  logic [WIDTH-1:0]   iterResult;

  assign mulSum   = {1'b0, hi} + (lo[0] ? {1'b0, opB} : '0);
  assign divShift = {hi, lo[WIDTH-1]};
  assign divOk    = divShift >= {1'b0, opB};
  assign divDiff  = divShift[WIDTH-1:0] - opB;

  always_comb begin
    nextHi = mulSum[WIDTH:1];
    nextLo = {mulSum[0], lo[WIDTH-1:1]};
    if (op[2]) begin
      nextHi = divOk ? divDiff : divShift[WIDTH-1:0];
      nextLo = {lo[WIDTH-2:0], divOk};
    end
  end

  assign mulFull = negRes ? -{nextHi, nextLo} : {nextHi, nextLo};
  assign divOut  = op[1] ? nextHi : nextLo;

  always_comb begin
    iterResult = mulFull[2*WIDTH-1:WIDTH];
    if (op[2])
      iterResult = negRes ? -divOut : divOut;
    else if (op == OP_MUL)
      iterResult = mulFull[WIDTH-1:0];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fastProd;
  logic [2*WIDTH-1:0] fastFull;
  logic [WIDTH-1:0]   fastResult;

  assign fastProd   = {{WIDTH{1'b0}}, absA} * {{WIDTH{1'b0}}, absB};
  assign fastFull   = negAccept ? -fastProd : fastProd;
  assign fastResult = (select == OP_MUL) ? fastFull[WIDTH-1:0] : fastFull[2*WIDTH-1:WIDTH];
`endif

  // Control FSM; accepting in DONE gives back-to-back operation without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op     <= '0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      opB    <= '0;
      negRes <= 1'b0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          valid <= 1'b0;
          state <= IDLE;
          if (accept) begin
            op <= select;
            if (special) begin
              result <= specialResult;
              valid  <= 1'b1;
              state  <= DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!select[2]) begin
              result <= fastResult;
              valid  <= 1'b1;
              state  <= DONE;
`endif
            end else begin
              hi     <= '0;
              lo     <= absA;
              opB    <= absB;
              negRes <= negAccept;
              count  <= '0;
              busy   <= 1'b1;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          hi    <= nextHi;
          lo    <= nextLo;
          count <= count + 1'b1;
          if (count == CW'(WIDTH-1)) begin
            result <= iterResult;
            busy   <= 1'b0;
            valid  <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
